// File: rtl/uart_tx_fifo_drain.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_drain
//   UART transmitter that drains a synchronous FIFO directly. Whenever the line
//   is idle and the FIFO is non-empty it pops the head word and sends it as an
//   8N1 frame (8E1 when parity is enabled). A built-in baud generator produces
//   one oversample tick every DVSR clocks; every bit lasts 16 ticks, and the
//   stop bit lasts SB_TICK ticks.
//
//   Optional feature: define UART_TX_PARITY_EN to add an even-parity bit
//   between the last data bit and the stop bit.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-high reset
//   fifo_empty    in   FIFO empty flag
//   fifo_data     in   FIFO head word (DBIT), valid while fifo_empty=0
//   fifo_rd       out  FIFO pop strobe, one cycle per word
//   tx            out  serial line, idle high (registered)
//   tx_busy       out  high whenever a frame is in progress
//   tx_done_tick  out  one-cycle pulse on the last stop-bit tick
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx_fifo_drain #(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int DVSR     = 163,
  parameter int DVSR_BIT = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  // Tick counter must hold both 0..15 (start/data/parity) and 0..SB_TICK-1.
  localparam int TICK_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NBIT_W = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [TICK_W-1:0]   BIT_LAST  = TICK_W'(15);
  localparam logic [TICK_W-1:0]   STOP_LAST = TICK_W'(SB_TICK - 1);
  localparam logic [NBIT_W-1:0]   DATA_LAST = NBIT_W'(DBIT - 1);
  localparam logic [DVSR_BIT-1:0] BAUD_LAST = DVSR_BIT'(DVSR - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t              state_q;
  logic [DVSR_BIT-1:0] baud_q, baud_d;
  logic [TICK_W-1:0]   s_q;
  logic [NBIT_W-1:0]   n_q;
  logic [DBIT-1:0]     b_q;
  logic [DBIT-1:0]     b_shift;
  logic                tx_q;
  logic                s_tick;
`ifdef UART_TX_PARITY_EN
  logic                par_q;
`endif

  // Baud generator: free-runs 0..DVSR-1 while a frame is active, parked at 0
  // in IDLE so the first tick of a frame always lands DVSR clocks after pop.
  assign s_tick = (baud_q == BAUD_LAST);

  always_comb begin
    // NOTE: assign a default first so no path through the block leaves the
    // signal unassigned; otherwise a latch is inferred.
    baud_d = baud_q + 1'b1;
    if (state_q == IDLE || s_tick) baud_d = '0;
  end

  assign b_shift = b_q >> 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      baud_q <= baud_d;
      unique case (state_q)
        IDLE: begin
          // The word is captured on the same edge that pops it, so later FIFO
          // activity cannot disturb the frame in flight.
          if (!fifo_empty) begin
            state_q <= START;
            b_q     <= fifo_data;
            s_q     <= '0;
            tx_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^fifo_data;
`endif
          end
        end
        START: begin
          if (s_tick) begin
            if (s_q == BIT_LAST) begin
              state_q <= DATA;
              s_q     <= '0;
              n_q     <= '0;
              tx_q    <= b_q[0];
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_q == BIT_LAST) begin
              s_q <= '0;
              if (n_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                state_q <= PARITY;
                tx_q    <= par_q;
`else
                state_q <= STOP;
                tx_q    <= 1'b1;
`endif
              end else begin
                n_q  <= n_q + 1'b1;
                b_q  <= b_shift;
                tx_q <= b_shift[0];
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (s_q == BIT_LAST) begin
              state_q <= STOP;
              s_q     <= '0;
              tx_q    <= 1'b1;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (s_tick) begin
            if (s_q == STOP_LAST) begin
              state_q <= IDLE;
              s_q     <= '0;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pop is decoded from registered state; it is masked during reset so the
  // FIFO cannot lose a word on an edge the transmitter ignores.
  assign fifo_rd      = (state_q == IDLE) && !fifo_empty && !reset;
  assign tx           = tx_q;
  assign tx_busy      = (state_q != IDLE);
  assign tx_done_tick = (state_q == STOP) && s_tick && (s_q == STOP_LAST);

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
`timescale 1ns/1ps

module tb_uart_tx_fifo_drain;

  localparam int DBIT     = 8;
  localparam int SB_TICK  = 16;
  localparam int DVSR     = 4;
  localparam int DVSR_BIT = 3;
  localparam int BIT_CLKS = 16 * DVSR;   // 64 clocks per bit
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CLKS = NBITS * BIT_CLKS;
  localparam int NRAND      = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd;
  logic       tx;
  logic       tx_busy;
  logic       tx_done_tick;

  always #5 clk = ~clk;

  uart_tx_fifo_drain #(
    .DBIT(DBIT), .SB_TICK(SB_TICK), .DVSR(DVSR), .DVSR_BIT(DVSR_BIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_rd     (fifo_rd),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .tx_done_tick(tx_done_tick)
  );

  // ---------------- FIFO model ----------------
  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr = '0;
  logic [7:0] rd_ptr = '0;
  int         pop_cnt  = 0;
  int         bad_pops = 0;
  int         push_cnt = 0;
  logic [7:0] exp_q[$];

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_data  = mem[rd_ptr];

  always @(posedge clk) begin
    if (fifo_rd) begin
      rd_ptr  <= rd_ptr + 1'b1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (fifo_rd && (fifo_empty || tx_busy || tx_done_tick)) bad_pops++;
  end

  task automatic push(input logic [7:0] b, input bit expect_rx);
    mem[wr_ptr] = b;
    wr_ptr      = wr_ptr + 1'b1;
    push_cnt++;
    if (expect_rx) exp_q.push_back(b);
  endtask

  // ---------------- independent UART receiver ----------------
  logic [7:0] rx_q[$];
  int         rx_framing_err = 0;

  initial begin : receiver
    logic [10:0] bits;
    bit          aborted;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        aborted = 1'b0;
        bits    = '0;
        for (int c = 1; c <= (NBITS - 1) * BIT_CLKS + BIT_CLKS / 2; c++) begin
          @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          if (c % BIT_CLKS == BIT_CLKS / 2) bits[c / BIT_CLKS] = tx;
        end
        if (!aborted) begin
          rx_q.push_back(bits[8:1]);
          if (bits[0] !== 1'b0 || bits[NBITS-1] !== 1'b1) rx_framing_err++;
          if (NBITS == 11 && bits[9] !== ^bits[8:1]) rx_framing_err++;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected line level for bit slot k of a frame carrying d.
  function automatic logic exp_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (NBITS == 11 && k == 9) return ^d;
    return 1'b1;
  endfunction

  // Call at a point where the DUT is idle with fifo_rd high. Follows the frame
  // cycle by cycle (cycle 0 = first clock after the pop edge) and returns at
  // cycle FRAME_CLKS, one clock after the done tick.
  task automatic run_frame(input logic [7:0] d, input bit more, input string tag,
                           output logic empty_after_pop);
    logic [NBITS-1:0] t_first, t_last;
    int               done_cnt = 0;
    int               done_at  = -1;
    bit               busy_ok  = 1'b1;
    bit               rd_ok    = 1'b1;
    check($sformatf("%s pop", tag), {29'd0, fifo_rd, tx_busy, tx}, 32'b101);
    @(negedge clk);
    empty_after_pop = fifo_empty;
    for (int c = 0; c < FRAME_CLKS; c++) begin
      if (c % BIT_CLKS == 0)            t_first[c / BIT_CLKS] = tx;
      if (c % BIT_CLKS == BIT_CLKS - 1) t_last[c / BIT_CLKS]  = tx;
      if (tx_done_tick) begin
        done_cnt++;
        done_at = c;
      end
      if (!tx_busy) busy_ok = 1'b0;
      if (fifo_rd)  rd_ok   = 1'b0;
      @(negedge clk);
    end
    for (int k = 0; k < NBITS; k++)
      check($sformatf("%s bit%0d", tag, k), {30'd0, t_first[k], t_last[k]},
            {30'd0, exp_bit(d, k), exp_bit(d, k)});
    check($sformatf("%s done_at", tag), done_at, FRAME_CLKS - 1);
    check($sformatf("%s done_cnt", tag), done_cnt, 1);
    check($sformatf("%s busy/no-pop in frame", tag), {30'd0, busy_ok, rd_ok}, 32'b11);
    check($sformatf("%s end", tag), {29'd0, tx, tx_busy, fifo_rd}, {29'd0, 1'b1, 1'b0, more});
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [7:0] rv [NRAND];
    logic       e;
    bit         idle_ok;

    // Reset with FIFO empty; outputs must settle before any clock edge.
    reset = 1'b1;
    #1;
    check("reset async", {28'd0, tx, fifo_rd, tx_busy, tx_done_tick}, 32'b1000);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle_ok = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_rd !== 1'b0 || tx_busy !== 1'b0 || tx_done_tick !== 1'b0)
        idle_ok = 1'b0;
    end
    check("idle 1000 clk", idle_ok, 1);

    // Single frame 0xA5: line 0,1,0,1,0,0,1,0,1,1.
    push(8'hA5, 1'b1);
    #1;
    run_frame(8'hA5, 1'b0, "a5", e);
    check("a5 pops", pop_cnt, 1);

    // Back-to-back frames with one idle-high clock between them.
    push(8'h01, 1'b1);
    push(8'h80, 1'b1);
    push(8'hFF, 1'b1);
    #1;
    run_frame(8'h01, 1'b1, "b2b 01", e);
    run_frame(8'h80, 1'b1, "b2b 80", e);
    run_frame(8'hFF, 1'b0, "b2b ff", e);
    check("b2b empty after third pop", e, 1);
    check("b2b pops", pop_cnt, 4);

    // Reset mid-frame at clock 300 of 0x3C; a word written mid-frame must wait.
    push(8'h3C, 1'b0);
    #1;
    check("3c pop", {30'd0, fifo_rd, tx_busy}, 32'b10);
    @(negedge clk);
    repeat (150) @(negedge clk);
    push(8'h5A, 1'b1);
    #1;
    check("3c mid-frame bit1", {30'd0, tx, fifo_rd}, 32'b00);
    @(negedge clk);
    repeat (149) @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("reset mid-frame", {28'd0, tx, tx_busy, fifo_rd, tx_done_tick}, 32'b1000);
    repeat (3) @(negedge clk);
    check("no pop in reset", pop_cnt, 5);
    reset = 1'b0;
    #1;
    run_frame(8'h5A, 1'b0, "after reset 5a", e);
    check("5a pops", pop_cnt, 6);

    // Parity-sensitive bytes (odd and even weight).
    push(8'h07, 1'b1);
    #1;
    run_frame(8'h07, 1'b0, "07", e);
    push(8'h03, 1'b1);
    #1;
    run_frame(8'h03, 1'b0, "03", e);

    // Burst of random bytes queued up front.
    for (int i = 0; i < NRAND; i++) begin
      rv[i] = 8'($urandom_range(0, 255));
      push(rv[i], 1'b1);
    end
    #1;
    for (int i = 0; i < NRAND; i++)
      run_frame(rv[i], i < NRAND - 1, $sformatf("rand%0d", i), e);

    repeat (10) @(negedge clk);
    check("rx count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("rx[%0d]", i), (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
    check("rx framing", rx_framing_err, 0);
    check("total pops", pop_cnt, push_cnt);
    check("pop while empty/busy", bad_pops, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
